// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path:
// default clock/baud/depth and receiver FSM encodings.
package uart_pkg;

    localparam int CLK_DEF   = 28000000;
    localparam int BPS_DEF   = 115200;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO, DEPTH x 8, for the UART receiver.
// Ports: clk, rst, push/wdata, pop, rdata (0 when empty), count, full, empty.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO wins.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with receive FIFO and hysteretic RTS flow control.
// Ports: clk, rst, rx, data_read (pop on fall); rxdata, rxrecv, rts, overflow, frame_err.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK   = CLK_DEF,
    parameter int BPS   = BPS_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_read,
    output logic [7:0] rxdata,
    output logic       rxrecv,
    output logic       rts,
    output logic       overflow,
    output logic       frame_err
);
    localparam int DIV = CLK / BPS;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(DEPTH);

    localparam logic [CW-1:0] DIV_FULL = CW'(DIV);
    localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2);
    localparam logic [AW:0]   RTS_ON   = (AW+1)'(DEPTH - 4);
    localparam logic [AW:0]   RTS_OFF  = (AW+1)'(DEPTH / 2);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_q;
    logic [7:0]    byte_q;
    logic          dr_q;
    logic          pop;
    logic          expire;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            dr_q    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            dr_q    <= data_read;
        end
    end

    assign pop = dr_q && !data_read;

    // Counter loaded with N expires N cycles later.
    assign expire = (baud_cnt <= CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            if (!expire)
                baud_cnt <= baud_cnt - 1'b1;
            unique case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        baud_cnt <= DIV_HALF;
                        state    <= START;
                    end
                end
                START: begin
                    if (expire) begin
                        if (!rx_sync) begin
                            baud_cnt <= DIV_FULL;
                            bit_idx  <= '0;
                            state    <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expire) begin
                        shreg    <= {rx_sync, shreg[7:1]};
                        baud_cnt <= DIV_FULL;
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (expire) begin
                        if (rx_sync) begin
                            push_q <= 1'b1;
                            byte_q <= shreg;
                            state  <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rts      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_q && full && !pop;
            if (count >= RTS_ON)
                rts <= 1'b1;
            else if (count <= RTS_OFF)
                rts <= 1'b0;
        end
    end

    uart_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata (byte_q),
        .pop   (pop),
        .rdata (rxdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign rxrecv = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model.
// Ports: drives clk, rst, rx, data_read; observes all outputs.
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 13_824_000;
    localparam int BPS    = 115_200;
    localparam int DEPTH  = 16;
    localparam int DIV    = CLK_HZ / BPS;
    // Posedges from driving the start bit to the stop-bit sample edge:
    // two synchroniser flops, one detect edge, half a bit, nine bits.
    localparam int STOP_EDGE = 3 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       data_read;
    logic [7:0] rxdata;
    logic       rxrecv;
    logic       rts;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK   (CLK_HZ),
        .BPS   (BPS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_read (data_read),
        .rxdata    (rxdata),
        .rxrecv    (rxrecv),
        .rts       (rts),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    int n_chk   = 0;
    int n_pass  = 0;
    int n_ovf   = 0;
    int n_fe    = 0;
    int ovf_exp = 0;
    int fe_exp  = 0;

    logic [7:0] q[$];
    bit         rts_m = 1'b0;

    always @(negedge clk) begin
        if (overflow === 1'b1)
            n_ovf++;
        if (frame_err === 1'b1)
            n_fe++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void m_rts();
        if (q.size() >= DEPTH - 4)
            rts_m = 1'b1;
        else if (q.size() <= DEPTH / 2)
            rts_m = 1'b0;
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (q.size() < DEPTH)
            q.push_back(b);
        else
            ovf_exp++;
        m_rts();
    endfunction

    function automatic void m_pop();
        if (q.size() > 0)
            void'(q.pop_front());
        m_rts();
    endfunction

    function automatic logic [7:0] m_head();
        if (q.size() == 0)
            return 8'h00;
        return q[0];
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".recv"}, rxrecv, q.size() != 0);
        check({tag, ".data"}, rxdata, m_head());
        check({tag, ".rts"}, rts, rts_m);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        rx = 1'b1;
        tick(2);
        m_push(b);
    endtask

    task automatic host_read(input string tag, output logic [7:0] got);
        data_read = 1'b1;
        tick(1);
        @(negedge clk);
        got = rxdata;
        check({tag, ".head"}, rxdata, m_head());
        @(posedge clk);
        #1;
        tick(1);
        data_read = 1'b0;
        @(posedge clk);
        m_pop();
        @(negedge clk);
        check({tag, ".popped"}, rxrecv, q.size() != 0);
        tick(2);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         k;

        rst       = 1'b1;
        rx        = 1'b1;
        data_read = 1'b0;
        tick(4);
        @(negedge clk);
        check("rst.recv", rxrecv, 1'b0);
        check("rst.data", rxdata, 8'h00);
        check("rst.rts", rts, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.fe", frame_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(3);

        // Single byte, latency from the stop-bit start.
        b  = 8'hA5;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = 1'b1;
        k  = 0;
        while (!rxrecv && k < DIV) begin
            tick(1);
            k++;
        end
        check("a5.lat", (k >= DIV / 2) && (k <= DIV / 2 + 5), 1'b1);
        tick(DIV - k + 2);
        m_push(8'hA5);
        check_state("a5");
        host_read("a5.rd", b);

        // Fill past the RTS threshold, then overflow.
        for (int i = 0; i < 16; i++) begin
            send_good(8'(i));
            check_state($sformatf("fill%0d", i));
        end
        send_good(8'hFF);
        check("ovf.once", n_ovf, ovf_exp);
        check_state("ovf");
        for (int i = 0; i < 16; i++) begin
            host_read($sformatf("drain%0d", i), b);
            check($sformatf("drain%0d.val", i), b, 8'(i));
            check($sformatf("drain%0d.rts", i), rts, rts_m);
        end

        // Framing error followed by a long break.
        send_byte(8'h3C, 1'b0);
        fe_exp++;
        tick(2000);
        rx = 1'b1;
        tick(DIV);
        check("fe.once", n_fe, fe_exp);
        check_state("break");
        send_good(8'h55);
        check_state("after_break");

        // Short low glitch must not start a frame.
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(2 * DIV);
        check_state("glitch");

        // Reset in the middle of bit 4 of 8'hC3.
        b  = 8'hC3;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = b[4];
        tick(DIV / 2);
        rst = 1'b1;
        tick(1);
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        q.delete();
        rts_m = 1'b0;
        tick(2 * DIV);
        check_state("rst_mid");
        send_good(8'h81);
        check_state("r81");

        // Random traffic with random host reads.
        for (int i = 0; i < 6; i++) begin
            send_good(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1)
                host_read($sformatf("rnd%0d", i), b);
        end
        while (q.size() > 0)
            host_read("flush", b);
        check_state("flushed");

        // Full FIFO, pop and push in the same cycle.
        for (int i = 0; i < DEPTH; i++)
            send_good(8'($urandom_range(0, 255)));
        check_state("full");
        fork
            send_byte(8'h77, 1'b1);
            begin
                tick(STOP_EDGE - 3);
                data_read = 1'b1;
                tick(3);
                data_read = 1'b0;
            end
        join
        rx = 1'b1;
        tick(2);
        m_pop();
        m_push(8'h77);
        check("simul.ovf", n_ovf, ovf_exp);
        check_state("simul");
        for (int i = 0; i < DEPTH; i++)
            host_read($sformatf("last%0d", i), b);
        check("simul.last", b, 8'h77);
        check_state("end");
        check("end.ovf", n_ovf, ovf_exp);
        check("end.fe", n_fe, fe_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
